// File: rtl/pu_psum_accum.sv
// Partial-sum accumulator behind the PU adder tree: sums tile results per output point.
// Optional saturating adds (and a sticky ovf_o) when PU_PSUM_SAT_EN is defined.
module pu_psum_accum #(
    parameter int unsigned ACCUM_WD    = 20,
    parameter int unsigned PSUM_WD     = 24,
    parameter int unsigned TILE_NUM_WD = 4,
    parameter int unsigned OUT_NUM_WD  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic [TILE_NUM_WD-1:0] cfg_tile_num_i,
    input  logic [OUT_NUM_WD-1:0]  cfg_out_num_i,
    input  logic                   in_vld_i,
    output logic                   in_rdy_o,
    input  logic [ACCUM_WD-1:0]    accum_i,
    output logic                   out_vld_o,
    input  logic                   out_rdy_i,
    output logic [PSUM_WD-1:0]     psum_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ovf_o
);

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e                   r_state,    w_state_nxt;
    logic [PSUM_WD-1:0]       r_acc,      w_acc_nxt;
    logic [PSUM_WD-1:0]       r_psum,     w_psum_nxt;
    logic [TILE_NUM_WD-1:0]   r_tile_cnt, w_tile_cnt_nxt;
    logic [TILE_NUM_WD-1:0]   r_tiles,    w_tiles_nxt;
    logic [OUT_NUM_WD-1:0]    r_out_cnt,  w_out_cnt_nxt;
    logic [OUT_NUM_WD-1:0]    r_outs,     w_outs_nxt;
    logic                     r_done,     w_done_nxt;
    logic                     r_ovf,      w_ovf_nxt;

    logic [TILE_NUM_WD-1:0]   w_tiles_cfg;
    logic [OUT_NUM_WD-1:0]    w_outs_cfg;
    logic signed [PSUM_WD-1:0] w_accum_ext;
    logic [PSUM_WD-1:0]       w_sum;
    logic                     w_clamp;
    logic                     w_last_tile;
    logic                     w_last_out;

    assign w_tiles_cfg = (cfg_tile_num_i == '0) ? TILE_NUM_WD'(1) : cfg_tile_num_i;
    assign w_outs_cfg  = (cfg_out_num_i == '0)  ? OUT_NUM_WD'(1)  : cfg_out_num_i;
    assign w_accum_ext = PSUM_WD'($signed(accum_i));
    assign w_last_tile = (r_tile_cnt == r_tiles - TILE_NUM_WD'(1));
    assign w_last_out  = (r_out_cnt == r_outs - OUT_NUM_WD'(1));

`ifdef PU_PSUM_SAT_EN
    localparam logic [PSUM_WD-1:0] PsumMax = {1'b0, {(PSUM_WD-1){1'b1}}};
    localparam logic [PSUM_WD-1:0] PsumMin = {1'b1, {(PSUM_WD-1){1'b0}}};

    logic [PSUM_WD:0] w_sum_wide;

    // One guard bit: the top two bits disagree exactly when the signed add overflowed.
    assign w_sum_wide = {r_acc[PSUM_WD-1], r_acc} + {w_accum_ext[PSUM_WD-1], w_accum_ext};
    assign w_clamp    = w_sum_wide[PSUM_WD] ^ w_sum_wide[PSUM_WD-1];
    assign w_sum      = !w_clamp ? w_sum_wide[PSUM_WD-1:0] :
                        (w_sum_wide[PSUM_WD] ? PsumMin : PsumMax);
`else
    assign w_sum   = r_acc + w_accum_ext;
    assign w_clamp = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_psum_nxt     = r_psum;
        w_tile_cnt_nxt = r_tile_cnt;
        w_tiles_nxt    = r_tiles;
        w_out_cnt_nxt  = r_out_cnt;
        w_outs_nxt     = r_outs;
        w_done_nxt     = 1'b0;
        w_ovf_nxt      = r_ovf;

        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_tiles_nxt    = w_tiles_cfg;
                    w_outs_nxt     = w_outs_cfg;
                    w_acc_nxt      = '0;
                    w_tile_cnt_nxt = '0;
                    w_out_cnt_nxt  = '0;
                    w_ovf_nxt      = 1'b0;
                    w_state_nxt    = StAcc;
                end
            end
            StAcc: begin
                if (in_vld_i) begin
                    w_acc_nxt = w_sum;
                    if (w_clamp) begin
                        w_ovf_nxt = 1'b1;
                    end
                    if (w_last_tile) begin
                        w_psum_nxt     = w_sum;
                        w_tile_cnt_nxt = '0;
                        w_state_nxt    = StOut;
                    end else begin
                        w_tile_cnt_nxt = r_tile_cnt + TILE_NUM_WD'(1);
                    end
                end
            end
            StOut: begin
                if (out_rdy_i) begin
                    if (w_last_out) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_out_cnt_nxt = r_out_cnt + OUT_NUM_WD'(1);
                        w_acc_nxt     = '0;
                        w_state_nxt   = StAcc;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= StIdle;
            r_acc      <= '0;
            r_psum     <= '0;
            r_tile_cnt <= '0;
            r_tiles    <= '0;
            r_out_cnt  <= '0;
            r_outs     <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_psum     <= w_psum_nxt;
            r_tile_cnt <= w_tile_cnt_nxt;
            r_tiles    <= w_tiles_nxt;
            r_out_cnt  <= w_out_cnt_nxt;
            r_outs     <= w_outs_nxt;
            r_done     <= w_done_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    // Handshake outputs decode registered state only; no path from in_vld_i/out_rdy_i.
    assign in_rdy_o  = (r_state == StAcc);
    assign out_vld_o = (r_state == StOut);
    assign busy_o    = (r_state != StIdle);
    assign done_o    = r_done;
    assign psum_o    = r_psum;
    assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_pu_psum_accum.sv
// Self-checking bench for pu_psum_accum: a default-width instance plus a PSUM_WD=20 instance
// sharing stimulus, compared against a plain-arithmetic accumulation model.
module tb_pu_psum_accum;

    localparam int AW = 20;
    localparam int PW = 24;
    localparam int PWS = 20;
`ifdef PU_PSUM_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic [3:0]    cfg_tile_num_i = '0;
    logic [7:0]    cfg_out_num_i = '0;
    logic          in_vld_i = 1'b0;
    logic [AW-1:0] accum_i = '0;
    logic          out_rdy_i = 1'b0;

    logic          in_rdy_o, out_vld_o, busy_o, done_o, ovf_o;
    logic [PW-1:0] psum_o;
    logic          in_rdy_s, out_vld_s, busy_s, done_s, ovf_s;
    logic [PWS-1:0] psum_s;

    pu_psum_accum u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
        .cfg_tile_num_i(cfg_tile_num_i), .cfg_out_num_i(cfg_out_num_i),
        .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .accum_i(accum_i),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .psum_o(psum_o),
        .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
    );

    pu_psum_accum #(.ACCUM_WD(AW), .PSUM_WD(PWS), .TILE_NUM_WD(4), .OUT_NUM_WD(8)) u_dut_s (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
        .cfg_tile_num_i(cfg_tile_num_i), .cfg_out_num_i(cfg_out_num_i),
        .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_s), .accum_i(accum_i),
        .out_vld_o(out_vld_s), .out_rdy_i(out_rdy_i), .psum_o(psum_s),
        .busy_o(busy_s), .done_o(done_s), .ovf_o(ovf_s)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    int in_q[$];
    int got_q[$];
    int got_s_q[$];
    int first_vld;
    int early_done;
    int rdy_viol;
    int hs_diff;
    bit timed_out;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input int tiles, input int outs);
        cfg_tile_num_i = 4'(tiles);
        cfg_out_num_i  = 8'(outs);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cfg_tile_num_i = 4'(tiles + 5);
        cfg_out_num_i  = 8'(outs + 7);
    endtask

    // Feeds in_q, collects accepted outputs, stops in the cycle done_o is seen after the last one.
    task automatic run_job(input int outs, input int vld_pct, input int rdy_pct);
        int idx = 0;
        int cyc = 0;
        int v;
        got_q.delete();
        got_s_q.delete();
        first_vld = -1; early_done = 0; rdy_viol = 0; hs_diff = 0; timed_out = 1'b0;
        forever begin
            if (done_o) begin
                if (got_q.size() == outs) break;
                early_done++;
            end
            if (cyc >= 2000) begin
                timed_out = 1'b1;
                break;
            end
            if (out_vld_o && first_vld < 0) first_vld = cyc;
            if (out_vld_o && in_rdy_o) rdy_viol++;
            if (in_rdy_s !== in_rdy_o || out_vld_s !== out_vld_o ||
                busy_s !== busy_o || done_s !== done_o) hs_diff++;
            if (idx < in_q.size()) begin
                v = in_q[idx];
                accum_i  = v[AW-1:0];
                in_vld_i = (int'($urandom_range(99)) < vld_pct);
            end else begin
                in_vld_i = 1'b0;
            end
            out_rdy_i = (int'($urandom_range(99)) < rdy_pct);
            if (in_vld_i && in_rdy_o) idx++;
            if (out_vld_o && out_rdy_i) begin
                got_q.push_back(int'($signed(psum_o)));
                got_s_q.push_back(int'($signed(psum_s)));
            end
            tick();
            cyc++;
        end
        in_vld_i  = 1'b0;
        out_rdy_i = 1'b0;
    endtask

    // Reference: running sum of one group of in_q, each add wrapped or clamped to w bits.
    function automatic int model_psum(input int first, input int n, input int w, input bit sat,
                                      inout bit ovf);
        longint acc = 0;
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        longint m  = longint'(1) << w;
        longint r;
        for (int i = 0; i < n; i++) begin
            acc = acc + longint'(in_q[first + i]);
            if (sat) begin
                if (acc > hi) begin acc = hi; ovf = 1'b1; end
                if (acc < lo) begin acc = lo; ovf = 1'b1; end
            end else begin
                r = (acc - lo) % m;
                if (r < 0) r = r + m;
                acc = r + lo;
            end
        end
        return int'(acc);
    endfunction

    task automatic test_reset();
        in_vld_i = 1'b0; out_rdy_i = 1'b0;
        rst_n_i = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({busy_o, in_rdy_o, out_vld_o, done_o, ovf_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy_o, in_rdy_o, out_vld_o, done_o, ovf_o});
        end
        n_checks++;
        if (psum_o !== '0) begin
            n_fail++; $display("FAIL reset_psum: got %0h want 0", psum_o);
        end
        rst_n_i = 1'b1;
        tick();
        do_start(4, 1);
        in_vld_i = 1'b1;
        accum_i = 20'd1000; tick();
        accum_i = 20'd2000; tick();
        in_vld_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, in_rdy_o, out_vld_o, done_o, ovf_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: got %b want 00000", {busy_o, in_rdy_o, out_vld_o, done_o, ovf_o});
        end
        n_checks++;
        if (psum_o !== '0) begin
            n_fail++; $display("FAIL reset_mid_psum: got %0h want 0", psum_o);
        end
        tick();
        rst_n_i = 1'b1;
        tick();
        n_checks++;
        if (out_vld_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_emit: vld %b busy %b want 0 0", out_vld_o, busy_o);
        end
        in_q = '{5, -3};
        do_start(2, 1);
        run_job(1, 100, 100);
        n_checks++;
        if (timed_out || got_q.size() != 1) begin
            n_fail++; $display("FAIL reset_job_count: got %0d outputs want 1", got_q.size());
        end else if (got_q[0] !== 2) begin
            n_fail++; $display("FAIL reset_job_psum: got %0d want 2", got_q[0]);
        end
    endtask

    task automatic test_basic();
        in_q = '{100, -200, 300, 7};
        do_start(4, 1);
        run_job(1, 100, 100);
        n_checks++;
        if (timed_out || got_q.size() != 1) begin
            n_fail++; $display("FAIL basic_count: got %0d outputs want 1", got_q.size());
        end else if (got_q[0] !== 207) begin
            n_fail++; $display("FAIL basic_psum: got %0d want 207", got_q[0]);
        end
        n_checks++;
        if (first_vld !== 4) begin
            n_fail++; $display("FAIL basic_latency: out_vld at cycle %0d want 4", first_vld);
        end
        n_checks++;
        if (busy_o !== 1'b0 || early_done !== 0) begin
            n_fail++; $display("FAIL basic_done_busy: busy %b early %0d want 0 0", busy_o, early_done);
        end
        tick();
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_pulse: done %b want 0", done_o);
        end
    endtask

    task automatic test_tile_zero();
        int exp_v[3] = '{-1, 2, -524288};
        in_q = '{-1, 2, -524288};
        do_start(0, 3);
        run_job(3, 100, 100);
        n_checks++;
        if (timed_out || got_q.size() != 3) begin
            n_fail++; $display("FAIL t0_count: got %0d outputs want 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_q[i] !== exp_v[i]) begin
                    n_fail++; $display("FAIL t0_psum[%0d]: got %0d want %0d", i, got_q[i], exp_v[i]);
                end
            end
        end
        n_checks++;
        if (rdy_viol !== 0) begin
            n_fail++; $display("FAIL t0_in_rdy_in_out: %0d cycles want 0", rdy_viol);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        do_start(1, 1);
        in_vld_i = 1'b1; accum_i = 20'd42; out_rdy_i = 1'b0;
        tick();
        accum_i = 20'd99;
        for (int i = 0; i < 5; i++) begin
            start_i = 1'b1;
            cfg_tile_num_i = 4'(i + 2);
            tick();
            if (out_vld_o !== 1'b1 || in_rdy_o !== 1'b0 || busy_o !== 1'b1 ||
                psum_o !== PW'(42)) bad++;
        end
        start_i = 1'b0; in_vld_i = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL stall_stable: %0d unstable cycles want 0", bad);
        end
        out_rdy_i = 1'b1;
        tick();
        out_rdy_i = 1'b0;
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_done: done %b busy %b want 1 0", done_o, busy_o);
        end
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_start_ignored: busy %b done %b want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_sat();
        bit ovf_exp = 1'b0;
        int exp_s;
        in_q = '{524287, 1};
        exp_s = model_psum(0, 2, PWS, SatEn, ovf_exp);
        do_start(2, 1);
        run_job(1, 100, 100);
        n_checks++;
        if (timed_out || got_q.size() != 1) begin
            n_fail++; $display("FAIL sat_count: got %0d outputs want 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== 524288) begin
                n_fail++; $display("FAIL sat_wide_psum: got %0d want 524288", got_q[0]);
            end
            n_checks++;
            if (got_s_q[0] !== exp_s) begin
                n_fail++; $display("FAIL sat_narrow_psum: got %0d want %0d", got_s_q[0], exp_s);
            end
        end
        n_checks++;
        if (ovf_s !== ovf_exp || ovf_o !== 1'b0) begin
            n_fail++; $display("FAIL sat_ovf: narrow %b wide %b want %b 0", ovf_s, ovf_o, ovf_exp);
        end
    endtask

    task automatic test_random();
        bit ovf_w = 1'b0;
        bit ovf_n = 1'b0;
        int exp_w, exp_n;
        logic signed [AW-1:0] r;
        in_q.delete();
        for (int i = 0; i < 12; i++) begin
            r = AW'($urandom);
            in_q.push_back(int'(r));
        end
        in_q[0] = 524287; in_q[1] = 524287;  // push the narrow instance past its range
        do_start(3, 4);
        run_job(4, 60, 50);
        n_checks++;
        if (timed_out || got_q.size() != 4) begin
            n_fail++; $display("FAIL rnd_count: got %0d outputs want 4", got_q.size());
        end else begin
            for (int p = 0; p < 4; p++) begin
                exp_w = model_psum(p * 3, 3, PW, SatEn, ovf_w);
                exp_n = model_psum(p * 3, 3, PWS, SatEn, ovf_n);
                n_checks++;
                if (got_q[p] !== exp_w) begin
                    n_fail++; $display("FAIL rnd_psum[%0d]: got %0d want %0d", p, got_q[p], exp_w);
                end
                n_checks++;
                if (got_s_q[p] !== exp_n) begin
                    n_fail++; $display("FAIL rnd_psum_narrow[%0d]: got %0d want %0d", p, got_s_q[p], exp_n);
                end
            end
        end
        n_checks++;
        if (ovf_s !== ovf_n || ovf_o !== ovf_w) begin
            n_fail++; $display("FAIL rnd_ovf: narrow %b wide %b want %b %b", ovf_s, ovf_o, ovf_n, ovf_w);
        end
        n_checks++;
        if (early_done !== 0 || rdy_viol !== 0 || hs_diff !== 0) begin
            n_fail++;
            $display("FAIL rnd_protocol: early_done %0d rdy_viol %0d hs_diff %0d want 0 0 0",
                     early_done, rdy_viol, hs_diff);
        end
        tick();
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++; $display("FAIL rnd_single_done: done %b want 0", done_o);
        end
    endtask

    task automatic test_back_to_back();
        in_q = '{3, 4};
        do_start(1, 2);
        run_job(2, 100, 100);
        n_checks++;
        if (timed_out || got_q.size() != 2 || got_q[0] !== 3 || got_q[1] !== 4) begin
            n_fail++; $display("FAIL b2b_first_job: got %0d outputs, want 3 then 4", got_q.size());
        end
        n_checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done_cycle: done %b busy %b want 1 0", done_o, busy_o);
        end
        in_q = '{10, 20};
        do_start(2, 1);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart: busy %b want 1", busy_o);
        end
        run_job(1, 100, 100);
        n_checks++;
        if (timed_out || got_q.size() != 1) begin
            n_fail++; $display("FAIL b2b_second_count: got %0d outputs want 1", got_q.size());
        end else if (got_q[0] !== 30) begin
            n_fail++; $display("FAIL b2b_second_psum: got %0d want 30", got_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tile_zero();
        test_stall();
        test_sat();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pu_psum_accum.md
# pu_psum_accum

Sequential partial-sum accumulator downstream of the PU 4-input adder tree. Consumes one signed ACCUM_WD adder-tree result per valid/ready beat, accumulates a configured number of input-channel tiles into one signed PSUM_WD partial sum, and presents it on an output valid/ready handshake. Repeats for a configured number of output points per job, then pulses done.

## Interface
- ACCUM_WD, 20, width of the incoming adder-tree sum (signed two's complement)
- PSUM_WD, 24, width of the accumulated partial sum (signed); must be ≥ ACCUM_WD
- TILE_NUM_WD, 4, width of the tile-count configuration
- OUT_NUM_WD, 8, width of the output-point-count configuration
- clk_i  input  1  clock, all state on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- start_i  input  1  single-cycle job start; honoured only in IDLE
- cfg_tile_num_i  input  TILE_NUM_WD  tiles per output point; sampled on accepted start_i; 0 treated as 1
- cfg_out_num_i  input  OUT_NUM_WD  output points per job; sampled on accepted start_i; 0 treated as 1
- in_vld_i  input  1  accum_i valid
- in_rdy_o  output  1  block accepts accum_i
- accum_i  input  ACCUM_WD  signed adder-tree sum
- out_vld_o  output  1  psum_o valid
- out_rdy_i  input  1  downstream accepts psum_o
- psum_o  output  PSUM_WD  signed partial sum
- busy_o  output  1  job in progress (state ≠ IDLE)
- done_o  output  1  one-cycle pulse when final output point is accepted
- ovf_o  output  1  sticky overflow flag (see Configuration)

## Operation
- States: IDLE, ACC, OUT.
- IDLE: in_rdy_o=0, out_vld_o=0. start_i=1 → latch cfg (0→1), clear acc, tile_cnt, out_cnt, ovf_o; go ACC.
- ACC: in_rdy_o=1. Beat = in_vld_i & in_rdy_o. On beat: acc ← acc + sign_ext(accum_i, PSUM_WD); tile_cnt++. Beat where tile_cnt = tiles−1: result written to psum register, tile_cnt←0, go OUT.
- OUT: in_rdy_o=0, out_vld_o=1, psum_o stable until accepted. On out_vld_o & out_rdy_i: if out_cnt = outs−1 → done_o pulse next cycle-edge output, go IDLE; else out_cnt++, acc cleared, go ACC.
- start_i outside IDLE ignored; cfg changes outside accepted start have no effect.
- Arithmetic: signed two's complement, accum_i sign-extended to PSUM_WD before adding.
- Reset (any time, incl. mid-job): state IDLE; acc, psum_o, counters, ovf_o = 0; in_rdy_o, out_vld_o, busy_o, done_o = 0. No partial result is emitted after reset.

## Timing
- in_rdy_o, out_vld_o, busy_o are registered-state decodes (no combinational path from in_vld_i/out_rdy_i).
- Latency: out_vld_o asserts the cycle after the last tile beat; one input per cycle max in ACC.
- Job with T tiles, N outputs, always-valid input and always-ready output: T+1 cycles per point; done_o high the cycle after final output accept, same cycle busy_o falls.
- Back-to-back start_i accepted in the cycle busy_o is 0 (the cycle done_o is high).
- No input accepted while in OUT; upstream must hold in_vld_i/accum_i.

## Configuration
- PU_PSUM_SAT_EN defined: each add saturates to [−2^(PSUM_WD−1), 2^(PSUM_WD−1)−1]; any clamp sets ovf_o, held until next accepted start_i or reset.
- Not defined: adds wrap modulo 2^PSUM_WD; ovf_o tied 0.

## Test plan
- Reset mid-ACC after 2 of 4 beats → all outputs 0, state IDLE; new start with tiles=2, inputs 5, −3 → psum_o=2.
- tiles=4, outs=1, accum_i 100, −200, 300, 7 back-to-back, out_rdy_i=1 → psum_o=207 one cycle after 4th beat; done_o one pulse after accept.
- tiles=0 (→1), outs=3, inputs −1, 2, −524288 → three outputs −1, 2, −524288 in order; in_rdy_o=0 during each OUT.
- out_rdy_i held 0 for 5 cycles in OUT → psum_o/out_vld_o stable, in_rdy_o=0; start_i pulses during job ignored.
- PSUM_WD=20, tiles=2, inputs 524287, 1: with PU_PSUM_SAT_EN → psum_o=524287, ovf_o=1; without → psum_o=−524288, ovf_o=0.
- Random in_vld_i/out_rdy_i gaps, tiles=3, outs=4 → psums match software model, exactly one done_o.
